// File: rtl/learn_costs_pkg.sv
// Shared constants, FSM state type and entry-address helper for the neighbor-cost learner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Table layout in the byte-wide memory: a count word at COUNT_ADDR, then
// MAX_NEIGHBORS entries of ENTRY_BYTES each, starting at TABLE_BASE.
package learn_costs_pkg;

    localparam int WORD_WIDTH    = 16;
    localparam int ADDR_WIDTH    = 11;
    localparam int MAX_NEIGHBORS = 16;
    localparam int ENTRY_BYTES   = 10;

    localparam logic [ADDR_WIDTH-1:0] COUNT_ADDR = 11'h000;
    localparam logic [ADDR_WIDTH-1:0] TABLE_BASE = 11'h002;

    // Byte offsets of the word fields inside one entry
    localparam logic [ADDR_WIDTH-1:0] OFF_ID  = 11'd0;
    localparam logic [ADDR_WIDTH-1:0] OFF_BAT = 11'd2;
    localparam logic [ADDR_WIDTH-1:0] OFF_VAL = 11'd4;
    localparam logic [ADDR_WIDTH-1:0] OFF_CLU = 11'd6;
    localparam logic [ADDR_WIDTH-1:0] OFF_EPS = 11'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CNT,
        S_LD_CNT,
        S_RD_ID,
        S_CMP,
        S_WR_HIT,
        S_WR_NEW,
        S_DONE
    } state_t;

    // Byte address of entry idx
    function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [4:0] idx);
        return TABLE_BASE + ADDR_WIDTH'(idx) * ADDR_WIDTH'(ENTRY_BYTES);
    endfunction

endpackage

// File: rtl/learn_costs.sv
// Neighbor-cost learning engine: searches the neighbor table for fsourceID, updates a hit, appends a miss.
// Latency: 2 + 2*(entries searched) + writes + 1 cycles from the en-sampling edge to the done pulse.
// Backpressure: none; en is only sampled in IDLE, requests arriving while busy are dropped.
//
// Ports:
//   clock, nrst (sync, active-high)      : clock and reset
//   en, fsourceID, fbatteryStat, fValue,
//   fclusterID, initial_epsilon          : request and its payload, latched on acceptance
//   address, wr_en, mem_data_in          : memory byte address / write enable / write word (all registered)
//   mem_data_out                         : memory read word, valid one cycle after address
//   done                                 : one-cycle completion pulse
module learn_costs
    import learn_costs_pkg::*;
(
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] fsourceID,
    input  logic [WORD_WIDTH-1:0] fbatteryStat,
    input  logic [WORD_WIDTH-1:0] fValue,
    input  logic [WORD_WIDTH-1:0] fclusterID,
    input  logic [WORD_WIDTH-1:0] initial_epsilon,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  wr_en,
    input  logic [WORD_WIDTH-1:0] mem_data_out,
    output logic [WORD_WIDTH-1:0] mem_data_in,
    output logic                  done
);

    state_t                r_state, w_state;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr;
    logic                  r_wr_en, w_wr_en;
    logic [WORD_WIDTH-1:0] r_wdata, w_wdata;
    logic                  r_done,  w_done;
    logic [4:0]            r_cnt,   w_cnt;
    logic [4:0]            r_idx,   w_idx;
    logic [2:0]            r_step,  w_step;
    logic [2:0]            w_nstep;
    logic                  w_latch;
    logic                  w_new_go;

    logic [WORD_WIDTH-1:0] r_id, r_bat, r_val, r_clu, r_eps;

    assign address     = r_addr;
    assign wr_en       = r_wr_en;
    assign mem_data_in = r_wdata;
    assign done        = r_done;

    always_ff @(posedge clock) begin
        if (nrst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wr_en <= 1'b0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_step  <= '0;
            r_id    <= '0;
            r_bat   <= '0;
            r_val   <= '0;
            r_clu   <= '0;
            r_eps   <= '0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_wr_en <= w_wr_en;
            r_wdata <= w_wdata;
            r_done  <= w_done;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_step  <= w_step;
            if (w_latch) begin
                r_id  <= fsourceID;
                r_bat <= fbatteryStat;
                r_val <= fValue;
                r_clu <= fclusterID;
                r_eps <= initial_epsilon;
            end
        end
    end

    // Next-state logic also computes the next value of every registered output,
    // so the memory sees address/data/wr_en aligned with the state that owns them.
    always_comb begin
        w_state  = r_state;
        w_addr   = r_addr;
        w_wr_en  = 1'b0;
        w_wdata  = r_wdata;
        w_done   = 1'b0;
        w_cnt    = r_cnt;
        w_idx    = r_idx;
        w_step   = r_step;
        w_nstep  = r_step + 3'd1;
        w_latch  = 1'b0;
        w_new_go = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_latch = 1'b1;
                    w_addr  = COUNT_ADDR;
                    w_state = S_RD_CNT;
                end
            end
            S_RD_CNT: w_state = S_LD_CNT;
            S_LD_CNT: begin
                w_cnt = mem_data_out[4:0];
                w_idx = 5'd0;
                if (w_cnt == 5'd0) begin
                    w_new_go = 1'b1;
                end else begin
                    w_addr  = entry_addr(5'd0) + OFF_ID;
                    w_state = S_RD_ID;
                end
            end
            S_RD_ID: w_state = S_CMP;
            S_CMP: begin
                if (mem_data_out == r_id) begin
                    w_state = S_WR_HIT;
                    w_step  = 3'd0;
                    w_addr  = entry_addr(r_idx) + OFF_BAT;
                    w_wdata = r_bat;
                    w_wr_en = 1'b1;
                end else begin
                    w_idx = r_idx + 5'd1;
                    if (w_idx == r_cnt) begin
                        w_new_go = 1'b1;
                    end else begin
                        w_addr  = entry_addr(w_idx) + OFF_ID;
                        w_state = S_RD_ID;
                    end
                end
            end
            // battery, value, cluster occupy consecutive words
            S_WR_HIT: begin
                if (r_step == 3'd2) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end else begin
                    w_step  = w_nstep;
                    w_addr  = r_addr + 11'd2;
                    w_wdata = (r_step == 3'd0) ? r_val : r_clu;
                    w_wr_en = 1'b1;
                end
            end
            // step 0 (ID) is issued on entry; steps 1..4 fill fields, step 5 bumps the count
            S_WR_NEW: begin
                if (r_step == 3'd5) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end else begin
                    w_step  = w_nstep;
                    w_wr_en = 1'b1;
                    case (w_nstep)
                        3'd1: begin w_addr = entry_addr(r_cnt) + OFF_BAT; w_wdata = r_bat; end
                        3'd2: begin w_addr = entry_addr(r_cnt) + OFF_VAL; w_wdata = r_val; end
                        3'd3: begin w_addr = entry_addr(r_cnt) + OFF_CLU; w_wdata = r_clu; end
                        3'd4: begin w_addr = entry_addr(r_cnt) + OFF_EPS; w_wdata = r_eps; end
                        default: begin
                            w_addr  = COUNT_ADDR;
                            w_wdata = WORD_WIDTH'(r_cnt) + 16'd1;
                        end
                    endcase
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase

        // Miss path: a full table drops the request without touching memory
        if (w_new_go) begin
            if (w_cnt >= 5'(MAX_NEIGHBORS)) begin
                w_state = S_DONE;
                w_done  = 1'b1;
            end else begin
                w_state = S_WR_NEW;
                w_step  = 3'd0;
                w_addr  = entry_addr(w_cnt) + OFF_ID;
                w_wdata = r_id;
                w_wr_en = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_learn_costs.sv
module tb_learn_costs;

    logic        clock = 1'b0;
    logic        nrst;
    logic        en;
    logic [15:0] fsourceID, fbatteryStat, fValue, fclusterID, initial_epsilon;
    logic [10:0] address;
    logic        wr_en;
    logic [15:0] mem_data_out;
    logic [15:0] mem_data_in;
    logic        done;

    // memory model and preload port
    logic [7:0]  mem [0:2047];
    logic        mem_clr;
    logic        pre_we;
    logic [10:0] pre_addr;
    logic [15:0] pre_dat;
    logic [7:0]  snap [0:255];

    logic [26:0] exp_q [$];
    logic [26:0] obs_q [$];

    int n_pass  = 0;
    int n_total = 0;

    learn_costs dut (
        .clock          (clock),
        .nrst           (nrst),
        .en             (en),
        .fsourceID      (fsourceID),
        .fbatteryStat   (fbatteryStat),
        .fValue         (fValue),
        .fclusterID     (fclusterID),
        .initial_epsilon(initial_epsilon),
        .address        (address),
        .wr_en          (wr_en),
        .mem_data_out   (mem_data_out),
        .mem_data_in    (mem_data_in),
        .done           (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
        end else if (pre_we) begin
            mem[pre_addr]         <= pre_dat[7:0];
            mem[pre_addr + 11'd1] <= pre_dat[15:8];
        end else if (wr_en) begin
            mem[address]         <= mem_data_in[7:0];
            mem[address + 11'd1] <= mem_data_in[15:8];
        end
        mem_data_out <= {mem[address + 11'd1], mem[address]};
    end

    // write monitor: one write per cycle, sampled mid-cycle
    always @(negedge clock) begin
        if (wr_en) obs_q.push_back({address, mem_data_in});
    end

    function automatic logic [15:0] mw(input int a);
        return {mem[a+1], mem[a]};
    endfunction

    function automatic logic [10:0] ea(input int i);
        return 11'(2 + 10 * i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_new(input int cnt, input logic [15:0] id, bat, val, clu, eps);
        exp_q.push_back({ea(cnt) + 11'd0, id});
        exp_q.push_back({ea(cnt) + 11'd2, bat});
        exp_q.push_back({ea(cnt) + 11'd4, val});
        exp_q.push_back({ea(cnt) + 11'd6, clu});
        exp_q.push_back({ea(cnt) + 11'd8, eps});
        exp_q.push_back({11'h000, 16'(cnt + 1)});
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk({tag, "_wr"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic pw(input logic [10:0] a, input logic [15:0] d);
        @(negedge clock);
        pre_addr = a; pre_dat = d; pre_we = 1'b1;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    // en held for `hold` sampling edges; lat = cycle index (after edge0) in which done is high
    task automatic do_op(input logic [15:0] id, bat, val, clu, eps, input int hold, input int win,
                         output int lat, output int nd);
        lat = 0; nd = 0;
        @(negedge clock);
        fsourceID = id; fbatteryStat = bat; fValue = val; fclusterID = clu; initial_epsilon = eps;
        en = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= win; k++) begin
            @(negedge clock);
            if (k >= hold) en = 1'b0;
            if (done) begin
                nd++;
                if (lat == 0) lat = k;
            end
        end
    endtask

    initial begin
        int lat, nd, diffs, nw;
        en = 0; fsourceID = 0; fbatteryStat = 0; fValue = 0; fclusterID = 0; initial_epsilon = 0;
        pre_we = 0; pre_addr = 0; pre_dat = 0;
        nrst = 1; mem_clr = 1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_addr", address, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wdata", mem_data_in, 0);
        chk("rst_done", done, 0);
        @(negedge clock);
        nrst = 0; mem_clr = 0;
        obs_q.delete();

        // 1: empty table, new entry 0
        push_new(0, 16'd1, 16'd5, 16'd10, 16'd11, 16'd1);
        do_op(16'd1, 16'd5, 16'd10, 16'd11, 16'd1, 1, 20, lat, nd);
        chk("t1_lat", lat, 9);
        chk("t1_ndone", nd, 1);
        check_writes("t1");
        chk("t1_id", mw(2), 1);
        chk("t1_eps", mw(10), 1);
        chk("t1_cnt", mw(0), 1);

        // 2: hit on entry 0
        exp_q.push_back({11'd4, 16'd7});
        exp_q.push_back({11'd6, 16'd10});
        exp_q.push_back({11'd8, 16'd11});
        do_op(16'd1, 16'd7, 16'd10, 16'd11, 16'd99, 1, 20, lat, nd);
        chk("t2_lat", lat, 8);
        check_writes("t2");
        chk("t2_bat", mw(4), 7);
        chk("t2_eps", mw(10), 1);
        chk("t2_cnt", mw(0), 1);

        // 3: miss after one compare, new entry 1
        push_new(1, 16'd31, 16'd3, 16'd4, 16'd5, 16'd2);
        do_op(16'd31, 16'd3, 16'd4, 16'd5, 16'd2, 1, 20, lat, nd);
        chk("t3_lat", lat, 11);
        check_writes("t3");
        chk("t3_id", mw(12), 31);
        chk("t3_cnt", mw(0), 2);
        chk("t3_e0_id", mw(2), 1);
        chk("t3_e0_bat", mw(4), 7);

        // 4: full table, no match -> dropped
        pw(11'h000, 16'd16);
        for (int i = 2; i < 16; i++) pw(ea(i), 16'(100 + i));
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        obs_q.delete();
        do_op(16'd500, 16'd1, 16'd2, 16'd3, 16'd4, 1, 45, lat, nd);
        chk("t4_lat", lat, 35);
        chk("t4_ndone", nd, 1);
        check_writes("t4");
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) diffs++;
        chk("t4_mem_diffs", diffs, 0);

        // 5a: en held high while busy -> one operation
        pw(11'h000, 16'd2);
        obs_q.delete();
        push_new(2, 16'd40, 16'd41, 16'd42, 16'd43, 16'd44);
        do_op(16'd40, 16'd41, 16'd42, 16'd43, 16'd44, 5, 40, lat, nd);
        chk("t5_lat", lat, 13);
        chk("t5_ndone", nd, 1);
        check_writes("t5");
        chk("t5_cnt", mw(0), 3);

        // 5b: reset in the middle of a write burst
        @(negedge clock);
        fsourceID = 16'd50; fbatteryStat = 16'd51; fValue = 16'd52; fclusterID = 16'd53;
        initial_epsilon = 16'd54; en = 1'b1;
        @(posedge clock);
        @(negedge clock);
        en = 1'b0;
        nw = 0;
        for (int k = 0; k < 40 && nw < 2; k++) begin
            @(negedge clock);
            if (wr_en) nw++;
        end
        chk("t5b_reached_write", nw, 2);
        nrst = 1'b1;
        @(posedge clock);
        #1;
        chk("t5b_addr", address, 0);
        chk("t5b_wr_en", wr_en, 0);
        chk("t5b_wdata", mem_data_in, 0);
        chk("t5b_done", done, 0);
        @(negedge clock);
        nrst = 1'b0;
        @(negedge clock);
        obs_q.delete();
        chk("t5b_cnt", mw(0), 3);

        push_new(3, 16'd60, 16'd61, 16'd62, 16'd63, 16'd64);
        do_op(16'd60, 16'd61, 16'd62, 16'd63, 16'd64, 1, 30, lat, nd);
        chk("t6_lat", lat, 15);
        chk("t6_ndone", nd, 1);
        check_writes("t6");
        chk("t6_cnt", mw(0), 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
